id_stage_pipe: RTL and testbench



---
 rtl/id_stage_pipe.sv | 220 ++++++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: instruction decode with register file, ID/EX register,
// bubble/flush handling and a two-micro-op swap sequencer.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   Instruction         [31:26] op, [25:21] src1, [20:16] src2,
//                       [15:11] rd, [15:0] imm
//   in_valid            Instruction is valid
//   hazard_detected     insert a bubble this cycle
//   flush               kill the stage (priority over hazard)
//   WB_Write_Enable,
//   WB_Dest, WB_Data    register file write port
//   freeze              comb; IF/ID must hold Instruction (swap A)
//   ex_valid, Dest, Val1, Val2, Reg2, EXE_CMD, MEM_R_EN, MEM_W_EN,
//   WB_EN, single_src, Br_type   registered EXE payload
//
// Build option: ID_WB_BYPASS_EN forwards same-cycle WB data
// into both read ports (and into the swap_hold capture).

module id_stage_pipe #(
   parameter int         DATA_W     = 32,
   parameter int         REG_COUNT  = 32,
   parameter logic [5:0] SWP_OPCODE = 6'b101010,
   parameter logic [3:0] MOV_CMD    = 4'b0001,
   localparam int        ADDR_W     = $clog2(REG_COUNT)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       Instruction,
   input  logic              in_valid,
   input  logic              hazard_detected,
   input  logic              flush,
   input  logic              WB_Write_Enable,
   input  logic [ADDR_W-1:0] WB_Dest,
   input  logic [DATA_W-1:0] WB_Data,
   output logic              freeze,
   output logic              ex_valid,
   output logic [ADDR_W-1:0] Dest,
   output logic [DATA_W-1:0] Val1,
   output logic [DATA_W-1:0] Val2,
   output logic [DATA_W-1:0] Reg2,
   output logic [3:0]        EXE_CMD,
   output logic              MEM_R_EN,
   output logic              MEM_W_EN,
   output logic              WB_EN,
   output logic              single_src,
   output logic [1:0]        Br_type
);

   typedef enum logic {IDLE, SWP2} state_t;

   typedef struct packed {
      logic              v;
      logic [ADDR_W-1:0] dest;
      logic [DATA_W-1:0] val1;
      logic [DATA_W-1:0] val2;
      logic [DATA_W-1:0] reg2;
      logic [3:0]        cmd;
      logic              mr;
      logic              mw;
      logic              wb;
      logic              ss;
      logic [1:0]        br;
   } ex_t;

   logic [DATA_W-1:0] rf [REG_COUNT];

   state_t            state, state_d;
   logic [DATA_W-1:0] swap_hold, hold_d;
   ex_t               ex_q, ex_d;

   logic [5:0]        opc;
   logic [ADDR_W-1:0] src1, src2, rd;
   logic [15:0]       imm;
   logic [DATA_W-1:0] r1, r2, sext;

   assign opc  = Instruction[31:26];
   assign src1 = Instruction[21 +: ADDR_W];
   assign src2 = Instruction[16 +: ADDR_W];
   assign rd   = Instruction[11 +: ADDR_W];
   assign imm  = Instruction[15:0];
   assign sext = DATA_W'($signed(imm));

   // Read ports; r0 is hard-wired to zero.
   always_comb begin
      r1 = (src1 == '0) ? '0 : rf[src1];
      r2 = (src2 == '0) ? '0 : rf[src2];
`ifdef ID_WB_BYPASS_EN
      if (WB_Write_Enable && WB_Dest == src1 && src1 != '0)
         r1 = WB_Data;
      if (WB_Write_Enable && WB_Dest == src2 && src2 != '0)
         r2 = WB_Data;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < REG_COUNT; i++)
            rf[i] <= '0;
      end else if (WB_Write_Enable && WB_Dest != '0) begin
         rf[WB_Dest] <= WB_Data;
      end
   end

   // Control-unit table.
   logic [3:0] c_cmd;
   logic       c_mr, c_mw, c_wb, c_ss, c_imm;
   logic [1:0] c_br;

   always_comb begin
      c_cmd = 4'b0000;
      c_mr  = 1'b0;
      c_mw  = 1'b0;
      c_wb  = 1'b0;
      c_ss  = 1'b0;
      c_imm = 1'b0;
      c_br  = 2'b00;
      unique case (opc)
         6'd1:  begin c_cmd = 4'b0000; c_wb = 1'b1; end
         6'd3:  begin c_cmd = 4'b0010; c_wb = 1'b1; end
         6'd5:  begin c_cmd = 4'b0100; c_wb = 1'b1; end
         6'd6:  begin c_cmd = 4'b0101; c_wb = 1'b1; end
         6'd7:  begin c_cmd = 4'b0110; c_wb = 1'b1; end
         6'd8:  begin c_cmd = 4'b0111; c_wb = 1'b1; end
         6'd9:  begin c_cmd = 4'b1000; c_wb = 1'b1; end
         6'd10: begin c_cmd = 4'b1000; c_wb = 1'b1; end
         6'd11: begin c_cmd = 4'b1001; c_wb = 1'b1; end
         6'd12: begin c_cmd = 4'b1010; c_wb = 1'b1; end
         6'd32: begin
            c_cmd = 4'b0000; c_wb = 1'b1; c_ss = 1'b1; c_imm = 1'b1;
         end
         6'd33: begin
            c_cmd = 4'b0010; c_wb = 1'b1; c_ss = 1'b1; c_imm = 1'b1;
         end
         6'd36: begin
            c_mr = 1'b1; c_wb = 1'b1; c_ss = 1'b1; c_imm = 1'b1;
         end
         6'd37: begin c_mw = 1'b1; c_imm = 1'b1; end
         6'd40: begin c_br = 2'b01; c_ss = 1'b1; c_imm = 1'b1; end
         6'd41: begin c_br = 2'b10; c_imm = 1'b1; end
         6'd43: begin c_br = 2'b11; c_ss = 1'b1; c_imm = 1'b1; end
         default: ;
      endcase
   end

   // Next ID/EX contents. Default is a bubble; flush beats hazard
   // beats issue. Micro-op B only needs swap_hold, so a hazard in
   // SWP2 just waits with the hold register untouched.
   always_comb begin
      ex_d    = '0;
      state_d = state;
      hold_d  = swap_hold;
      if (flush) begin
         state_d = IDLE;
      end else if (!hazard_detected) begin
         if (state == SWP2) begin
            ex_d.v    = 1'b1;
            ex_d.dest = src2;
            ex_d.val1 = swap_hold;
            ex_d.val2 = swap_hold;
            ex_d.reg2 = swap_hold;
            ex_d.cmd  = MOV_CMD;
            ex_d.wb   = 1'b1;
            ex_d.ss   = 1'b1;
            state_d   = IDLE;
         end else if (in_valid && opc == SWP_OPCODE) begin
            ex_d.v    = 1'b1;
            ex_d.dest = src1;
            ex_d.val1 = r2;
            ex_d.val2 = r2;
            ex_d.reg2 = r2;
            ex_d.cmd  = MOV_CMD;
            ex_d.wb   = 1'b1;
            ex_d.ss   = 1'b1;
            hold_d    = r1;
            state_d   = SWP2;
         end else if (in_valid) begin
            ex_d.v    = 1'b1;
            ex_d.dest = c_imm ? src2 : rd;
            ex_d.val1 = r1;
            ex_d.val2 = c_imm ? sext : r2;
            ex_d.reg2 = r2;
            ex_d.cmd  = c_cmd;
            ex_d.mr   = c_mr;
            ex_d.mw   = c_mw;
            ex_d.wb   = c_wb;
            ex_d.ss   = c_ss;
            ex_d.br   = c_br;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         swap_hold <= '0;
         ex_q      <= '0;
      end else begin
         state     <= state_d;
         swap_hold <= hold_d;
         ex_q      <= ex_d;
      end
   end

   assign freeze = !rst && in_valid && opc == SWP_OPCODE
                   && state == IDLE && !flush;

   assign ex_valid   = ex_q.v;
   assign Dest       = ex_q.dest;
   assign Val1       = ex_q.val1;
   assign Val2       = ex_q.val2;
   assign Reg2       = ex_q.reg2;
   assign EXE_CMD    = ex_q.cmd;
   assign MEM_R_EN   = ex_q.mr;
   assign MEM_W_EN   = ex_q.mw;
   assign WB_EN      = ex_q.wb;
   assign single_src = ex_q.ss;
   assign Br_type    = ex_q.br;

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: drives a 32x32 and a 16-bit/8-register
// id_stage_pipe from the same stimulus and checks both.

module tb_id_stage_pipe;

`ifdef ID_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] Instruction;
   logic        in_valid, hazard_detected, flush, WB_Write_Enable;
   logic [4:0]  WB_Dest;
   logic [31:0] WB_Data;

   logic        freeze_a, ex_valid_a, mr_a, mw_a, wb_a, ss_a;
   logic [4:0]  Dest_a;
   logic [31:0] Val1_a, Val2_a, Reg2_a;
   logic [3:0]  cmd_a;
   logic [1:0]  br_a;

   logic        freeze_b, ex_valid_b, mr_b, mw_b, wb_b, ss_b;
   logic [2:0]  Dest_b;
   logic [15:0] Val1_b, Val2_b, Reg2_b;
   logic [3:0]  cmd_b;
   logic [1:0]  br_b;

   always #5 clk = ~clk;

   id_stage_pipe u_a (
      .clk(clk), .rst(rst), .Instruction(Instruction),
      .in_valid(in_valid), .hazard_detected(hazard_detected),
      .flush(flush), .WB_Write_Enable(WB_Write_Enable),
      .WB_Dest(WB_Dest), .WB_Data(WB_Data), .freeze(freeze_a),
      .ex_valid(ex_valid_a), .Dest(Dest_a), .Val1(Val1_a),
      .Val2(Val2_a), .Reg2(Reg2_a), .EXE_CMD(cmd_a),
      .MEM_R_EN(mr_a), .MEM_W_EN(mw_a), .WB_EN(wb_a),
      .single_src(ss_a), .Br_type(br_a)
   );

   id_stage_pipe #(.DATA_W(16), .REG_COUNT(8)) u_b (
      .clk(clk), .rst(rst), .Instruction(Instruction),
      .in_valid(in_valid), .hazard_detected(hazard_detected),
      .flush(flush), .WB_Write_Enable(WB_Write_Enable),
      .WB_Dest(WB_Dest[2:0]), .WB_Data(WB_Data[15:0]),
      .freeze(freeze_b),
      .ex_valid(ex_valid_b), .Dest(Dest_b), .Val1(Val1_b),
      .Val2(Val2_b), .Reg2(Reg2_b), .EXE_CMD(cmd_b),
      .MEM_R_EN(mr_b), .MEM_W_EN(mw_b), .WB_EN(wb_b),
      .single_src(ss_b), .Br_type(br_b)
   );

   typedef struct packed {
      logic        v;
      logic [4:0]  dest;
      logic [31:0] val1;
      logic [31:0] val2;
      logic [31:0] reg2;
      logic [3:0]  cmd;
      logic        mr;
      logic        mw;
      logic        wb;
      logic        ss;
      logic [1:0]  br;
   } exp_t;

   typedef struct {
      string       name;
      logic [31:0] ins;
      exp_t        e;
   } vec_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   // ctl = {mr, mw, wb, ss, br[1:0]}
   function automatic exp_t mk(input logic [4:0] d,
                               input logic [31:0] a,
                               input logic [31:0] b,
                               input logic [31:0] r,
                               input logic [3:0] c,
                               input logic [5:0] ctl);
      exp_t e;
      e = {1'b1, d, a, b, r, c, ctl};
      return e;
   endfunction

   function automatic logic [31:0] ri(input logic [5:0] op,
                                      input logic [4:0] s1,
                                      input logic [4:0] s2,
                                      input logic [4:0] d);
      return {op, s1, s2, d, 11'b0};
   endfunction

   function automatic logic [31:0] ii(input logic [5:0] op,
                                      input logic [4:0] s1,
                                      input logic [4:0] s2,
                                      input logic [15:0] im);
      return {op, s1, s2, im};
   endfunction

   task automatic cmp(input string nm);
      exp_t e, e2, a, b;
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s scoreboard empty", nm);
         return;
      end
      e = sb.pop_front();
      e2 = e;
      e2.dest = {2'b00, e.dest[2:0]};
      e2.val1 = {16'h0, e.val1[15:0]};
      e2.val2 = {16'h0, e.val2[15:0]};
      e2.reg2 = {16'h0, e.reg2[15:0]};
      a = {ex_valid_a, Dest_a, Val1_a, Val2_a, Reg2_a,
           cmd_a, mr_a, mw_a, wb_a, ss_a, br_a};
      b = {ex_valid_b, 2'b00, Dest_b, 16'h0, Val1_b, 16'h0, Val2_b,
           16'h0, Reg2_b, cmd_b, mr_b, mw_b, wb_b, ss_b, br_b};
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s w32 got=%h exp=%h", nm, a, e);
      end
      checks++;
      if (b !== e2) begin
         failures++;
         $display("FAIL %s w16 got=%h exp=%h", nm, b, e2);
      end
   endtask

   task automatic step(input string nm, input exp_t e);
      sb.push_back(e);
      @(posedge clk);
      #1;
      cmp(nm);
   endtask

   task automatic chk_frz(input string nm, input logic ex);
      #1;
      checks++;
      if (freeze_a !== ex) begin
         failures++;
         $display("FAIL %s w32 freeze got=%b exp=%b", nm, freeze_a, ex);
      end
      checks++;
      if (freeze_b !== ex) begin
         failures++;
         $display("FAIL %s w16 freeze got=%b exp=%b", nm, freeze_b, ex);
      end
   endtask

   task automatic drv(input logic [31:0] ins, input logic iv,
                      input logic hz, input logic fl,
                      input logic we, input logic [4:0] wd,
                      input logic [31:0] wv);
      Instruction     = ins;
      in_valid        = iv;
      hazard_detected = hz;
      flush           = fl;
      WB_Write_Enable = we;
      WB_Dest         = wd;
      WB_Data         = wv;
   endtask

   task automatic wb(input logic [4:0] d, input logic [31:0] v);
      drv(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, d, v);
      step("preload", '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      automatic logic [31:0] swp = ii(6'b101010, 5'd1, 5'd2, 16'h0);
      automatic logic [31:0] add = ri(6'd1, 5'd1, 5'd2, 5'd3);
      automatic logic [31:0] mv  = 32'd1;
      vec_t vt[14];

      vt[0]  = '{"add",  ri(6'd1, 5'd1, 5'd2, 5'd3),
                 mk(5'd3, 32'd5, 32'd7, 32'd7, 4'd0, 6'b001000)};
      vt[1]  = '{"sub",  ri(6'd3, 5'd2, 5'd1, 5'd6),
                 mk(5'd6, 32'd7, 32'd5, 32'd5, 4'd2, 6'b001000)};
      vt[2]  = '{"and",  ri(6'd5, 5'd1, 5'd5, 5'd3),
                 mk(5'd3, 32'd5, 32'h20, 32'h20, 4'd4, 6'b001000)};
      vt[3]  = '{"xor",  ri(6'd8, 5'd5, 5'd2, 5'd7),
                 mk(5'd7, 32'h20, 32'd7, 32'd7, 4'd7, 6'b001000)};
      vt[4]  = '{"sra",  ri(6'd11, 5'd5, 5'd1, 5'd4),
                 mk(5'd4, 32'h20, 32'd5, 32'd5, 4'd9, 6'b001000)};
      vt[5]  = '{"addi", ii(6'd32, 5'd1, 5'd4, 16'hFFFE),
                 mk(5'd4, 32'd5, 32'hFFFFFFFE, 32'd0, 4'd0, 6'b001100)};
      vt[6]  = '{"subi", ii(6'd33, 5'd2, 5'd7, 16'h7FFF),
                 mk(5'd7, 32'd7, 32'h7FFF, 32'd0, 4'd2, 6'b001100)};
      vt[7]  = '{"ld",   ii(6'd36, 5'd5, 5'd6, 16'h0008),
                 mk(5'd6, 32'h20, 32'd8, 32'd0, 4'd0, 6'b101100)};
      vt[8]  = '{"st",   ii(6'd37, 5'd1, 5'd2, 16'h0004),
                 mk(5'd2, 32'd5, 32'd4, 32'd7, 4'd0, 6'b010000)};
      vt[9]  = '{"bez",  ii(6'd40, 5'd1, 5'd0, 16'h8000),
                 mk(5'd0, 32'd5, 32'hFFFF8000, 32'd0, 4'd0, 6'b000101)};
      vt[10] = '{"bne",  ii(6'd41, 5'd1, 5'd2, 16'h0003),
                 mk(5'd2, 32'd5, 32'd3, 32'd7, 4'd0, 6'b000010)};
      vt[11] = '{"jmp",  ii(6'd43, 5'd0, 5'd0, 16'h0010),
                 mk(5'd0, 32'd0, 32'h10, 32'd0, 4'd0, 6'b000111)};
      vt[12] = '{"nop",  32'h0,
                 mk(5'd0, 32'd0, 32'd0, 32'd0, 4'd0, 6'b000000)};
      vt[13] = '{"undef", ri(6'd63, 5'd1, 5'd2, 5'd3),
                 mk(5'd3, 32'd5, 32'd7, 32'd7, 4'd0, 6'b000000)};

      rst = 1'b1;
      drv(swp, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      @(posedge clk);
      #1;
      sb.push_back('0);
      cmp("reset");
      chk_frz("reset_frz", 1'b0);
      in_valid = 1'b0;
      rst = 1'b0;

      wb(5'd1, 32'd5);
      wb(5'd2, 32'd7);
      wb(5'd5, 32'h20);
      wb(5'd0, 32'h99);

      for (int i = 0; i < 14; i++) begin
         drv(vt[i].ins, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
         step(vt[i].name, vt[i].e);
      end

      drv(add, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      step("hazard_bubble", '0);
      drv(add, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      step("invalid_bubble", '0);

      wb(5'd1, 32'hA);
      wb(5'd2, 32'hB);

      drv(swp, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      chk_frz("swp_frz_a", 1'b1);
      step("swp_a", mk(5'd1, 32'hB, 32'hB, 32'hB, mv[3:0], 6'b001100));
      chk_frz("swp_frz_b", 1'b0);
      step("swp_b", mk(5'd2, 32'hA, 32'hA, 32'hA, mv[3:0], 6'b001100));
      drv(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      step("swp_done", '0);

      drv(swp, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      step("hz_a", mk(5'd1, 32'hB, 32'hB, 32'hB, mv[3:0], 6'b001100));
      drv(swp, 1'b1, 1'b1, 1'b0, 1'b1, 5'd1, 32'h77);
      chk_frz("hz_frz", 1'b0);
      step("hz_bub1", '0);
      drv(swp, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      step("hz_bub2", '0);
      drv(swp, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      step("hz_b", mk(5'd2, 32'hA, 32'hA, 32'hA, mv[3:0], 6'b001100));
      drv(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      step("hz_done", '0);

      drv(swp, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      step("fl_a", mk(5'd1, 32'hB, 32'hB, 32'hB, mv[3:0], 6'b001100));
      drv(swp, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
      chk_frz("fl_frz", 1'b0);
      step("fl_bub", '0);
      drv(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      step("fl_no_b", '0);

      drv(add, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
      step("fl_over_hz", '0);
      drv(swp, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
      chk_frz("fl_idle_frz", 1'b0);
      step("fl_idle_swp", '0);
      drv(add, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      step("fl_then_add",
           mk(5'd3, 32'h77, 32'hB, 32'hB, 4'd0, 6'b001000));

      drv(ri(6'd1, 5'd1, 5'd0, 5'd3), 1'b1, 1'b0, 1'b0,
          1'b1, 5'd1, 32'h55);
      step("wb_same", mk(5'd3, BYP ? 32'h55 : 32'h77, 32'd0, 32'd0,
                         4'd0, 6'b001000));
      drv(ri(6'd1, 5'd1, 5'd0, 5'd3), 1'b1, 1'b0, 1'b0,
          1'b0, 5'd0, 32'd0);
      step("wb_after", mk(5'd3, 32'h55, 32'd0, 32'd0, 4'd0, 6'b001000));
      drv(ri(6'd1, 5'd0, 5'd0, 5'd3), 1'b1, 1'b0, 1'b0,
          1'b1, 5'd0, 32'h99);
      step("wb_r0_same", mk(5'd3, 32'd0, 32'd0, 32'd0, 4'd0, 6'b001000));
      drv(ri(6'd1, 5'd0, 5'd0, 5'd3), 1'b1, 1'b0, 1'b0,
          1'b0, 5'd0, 32'd0);
      step("wb_r0_after", mk(5'd3, 32'd0, 32'd0, 32'd0, 4'd0, 6'b001000));

      drv(swp, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 32'h66);
      step("byp_a", mk(5'd1, 32'hB, 32'hB, 32'hB, mv[3:0], 6'b001100));
      drv(swp, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      step("byp_b", mk(5'd2, BYP ? 32'h66 : 32'h55,
                       BYP ? 32'h66 : 32'h55, BYP ? 32'h66 : 32'h55,
                       mv[3:0], 6'b001100));
      drv(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      step("byp_done", '0);

      drv(swp, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      step("rs_a", mk(5'd1, 32'hB, 32'hB, 32'hB, mv[3:0], 6'b001100));
      #2;
      rst = 1'b1;
      #1;
      sb.push_back('0);
      cmp("rst_async");
      chk_frz("rst_frz", 1'b0);
      in_valid = 1'b0;
      #1;
      rst = 1'b0;
      drv(add, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      step("rs_rf_clr", mk(5'd3, 32'd0, 32'd0, 32'd0, 4'd0, 6'b001000));
      wb(5'd1, 32'h3);
      wb(5'd2, 32'h4);
      drv(swp, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      chk_frz("rs_frz", 1'b1);
      step("rs_swp_a", mk(5'd1, 32'h4, 32'h4, 32'h4, mv[3:0], 6'b001100));
      step("rs_swp_b", mk(5'd2, 32'h3, 32'h3, 32'h3, mv[3:0], 6'b001100));
      drv(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      step("end_bubble", '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
